// File: rtl/keypad_matrix_scanner_pkg.sv
// keypad_pkg: shared FSM state, event record and one-hot helper for the keypad scanner
package keypad_pkg;
    localparam int CODE_MAX_W = 8;
    localparam int MAX_KEYS = 1 << CODE_MAX_W;
    typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_e;
    typedef struct packed {
        logic                  rpt;
        logic [CODE_MAX_W-1:0] code;
    } evt_t;
    function automatic logic is_one_hot(input logic [MAX_KEYS-1:0] v);
        return v != '0 && (v & (v - MAX_KEYS'(1))) == '0;
    endfunction
endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// keypad_matrix_scanner_if: key event stream (master: valid/code/repeat out, ready in; slave: mirror)
interface keypad_matrix_scanner_if #(parameter int CW = 4) ();
    logic          evt_valid;
    logic          evt_ready;
    logic [CW-1:0] evt_code;
    logic          evt_repeat;
    modport master (output evt_valid, evt_code, evt_repeat, input evt_ready);
    modport slave (input evt_valid, evt_code, evt_repeat, output evt_ready);
endinterface

// File: rtl/keypad_matrix_scanner_evt_fifo.sv
// keypad_evt_fifo: sync FIFO (clk, reset, push/din in, ready in, valid/dout out, overflow pulse on dropped push)
module keypad_evt_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic         overflow
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic ovf_q, ovf_d, full, pop, wr_en;
    always_comb begin
        valid = wr_q != rd_q;
        full = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
        pop = valid && ready;
        wr_en = push && (!full || pop);
        mem_d = mem_q;
        if (wr_en) mem_d[wr_q[AW-1:0]] = din;
        wr_d = wr_q + {{AW{1'b0}}, wr_en};
        rd_d = rd_q + {{AW{1'b0}}, pop};
        ovf_d = push && full && !pop;
        dout = valid ? mem_q[rd_q[AW-1:0]] : '0;
    end
    always_ff @(posedge clk) mem_q <= mem_d;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            ovf_q <= ovf_d;
        end
    end
    assign overflow = ovf_q;
endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: column scan, frame debounce, press/repeat FSM, event FIFO (clk, reset, rows in, cols out, evt master, multi_key, overflow)
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int N_ROWS = 4,
    parameter int N_COLS = 4,
    parameter int SCAN_TICKS = 50000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE = 100,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_ROWS-1:0] rows,
    output logic [N_COLS-1:0] cols,
    keypad_matrix_scanner_if.master evt,
    output logic              multi_key,
    output logic              overflow
);
    localparam int KEYS = N_ROWS * N_COLS;
    localparam int CW = $clog2(KEYS);
    localparam int TW = SCAN_TICKS > 1 ? $clog2(SCAN_TICKS) : 1;
    localparam int CLW = N_COLS > 1 ? $clog2(N_COLS) : 1;
    localparam int SW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int RW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
    logic [N_ROWS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [CLW-1:0] col_q, col_d;
    logic [KEYS-1:0] cur_q, cur_d, prev_q, prev_d, deb_q, deb_d;
    logic [SW-1:0] stable_q, stable_d;
    state_e state_q, state_d;
    logic [CW-1:0] key_q, key_d, code;
    logic [RW-1:0] rep_q, rep_d;
    logic push_q, push_d, multi_q, multi_d, sample, frame_end, single;
    evt_t evt_q, evt_d, head;
    always_comb begin
        sync1_d = rows;
        sync2_d = sync1_q;
        sample = tick_q == TW'(SCAN_TICKS - 1);
        frame_end = sample && col_q == CLW'(N_COLS - 1);
        tick_d = sample ? '0 : tick_q + TW'(1);
        col_d = !sample ? col_q : frame_end ? '0 : col_q + CLW'(1);
        cur_d = cur_q;
        for (int r = 0; r < N_ROWS; r++) if (sample) cur_d[r * N_COLS + int'(col_q)] = ~sync2_q[r];
        prev_d = frame_end ? cur_d : prev_q;
        stable_d = !frame_end ? stable_q : cur_d != prev_q ? '0 :
                   stable_q == SW'(DEBOUNCE_FRAMES) ? stable_q : stable_q + SW'(1);
        deb_d = frame_end && stable_d == SW'(DEBOUNCE_FRAMES) ? cur_d : deb_q;
        single = is_one_hot(MAX_KEYS'(deb_d));
        code = '0;
        for (int i = 0; i < KEYS; i++) if (deb_d[i]) code = CW'(i);
        multi_d = frame_end ? deb_d != '0 && !single : multi_q;
        state_d = state_q;
        key_d = key_q;
        rep_d = rep_q;
        push_d = 1'b0;
        evt_d = evt_q;
        if (frame_end) begin
            if (!single) state_d = IDLE;
            else if (state_q == IDLE || code != key_q) begin
                state_d = HELD;
                key_d = code;
                rep_d = '0;
                push_d = 1'b1;
                evt_d.rpt = 1'b0;
                evt_d.code = CODE_MAX_W'(code);
            end else if (state_q == HELD ? REPEAT_RATE != 0 && rep_q == RW'(REPEAT_DELAY - 1)
                                         : rep_q == RW'(REPEAT_RATE - 1)) begin
                state_d = REPEAT;
                rep_d = '0;
                push_d = 1'b1;
                evt_d.rpt = 1'b1;
                evt_d.code = CODE_MAX_W'(key_q);
            end else rep_d = rep_q + RW'(1);
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            tick_q <= '0;
            col_q <= '0;
            cur_q <= '0;
            prev_q <= '0;
            deb_q <= '0;
            stable_q <= '0;
            state_q <= IDLE;
            key_q <= '0;
            rep_q <= '0;
            push_q <= 1'b0;
            evt_q <= '0;
            multi_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            tick_q <= tick_d;
            col_q <= col_d;
            cur_q <= cur_d;
            prev_q <= prev_d;
            deb_q <= deb_d;
            stable_q <= stable_d;
            state_q <= state_d;
            key_q <= key_d;
            rep_q <= rep_d;
            push_q <= push_d;
            evt_q <= evt_d;
            multi_q <= multi_d;
        end
    end
    keypad_evt_fifo #(.W($bits(evt_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(push_q),
        .din(evt_q),
        .ready(evt.evt_ready),
        .valid(evt.evt_valid),
        .dout(head),
        .overflow(overflow)
    );
    assign cols = ~(N_COLS'(1) << col_q);
    assign evt.evt_code = head.code[CW-1:0];
    assign evt.evt_repeat = head.rpt;
    assign multi_key = multi_q;
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: directed and random keypad frames checked against a frame-level behavioural model
module tb_keypad_matrix_scanner;
    localparam int DEB = 2, DELAY = 3, RATE = 2, DEPTH = 2;
    typedef struct {int code; int rpt; int cyc;} ev_t;
    logic clk = 1'b0, reset = 1'b1;
    logic [3:0] rows, cols;
    logic [15:0] keys = '0;
    logic multi_key, overflow;
    int checks = 0, fails = 0, cyc = 0, n_seen = 0, ovf_seen = 0, ovf_exp = 0;
    logic [15:0] hist[$];
    logic [15:0] m_deb;
    bit m_active, m_mk, stall_prev;
    int m_cur, m_held, f_idx;
    ev_t exp_q[$];
    ev_t e;
    logic [3:0] p_code;
    logic p_rep;
    keypad_matrix_scanner_if #(.CW(4)) evt_if();
    keypad_matrix_scanner #(
        .N_ROWS(4), .N_COLS(4), .SCAN_TICKS(4), .DEBOUNCE_FRAMES(DEB),
        .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .rows(rows), .cols(cols), .evt(evt_if),
        .multi_key(multi_key), .overflow(overflow)
    );
    always #5 clk = ~clk;
    always @(posedge clk or posedge reset) cyc <= reset ? 0 : cyc + 1;
    always_comb begin
        rows = '1;
        for (int r = 0; r < 4; r++) rows[r] = ~|(keys[r*4 +: 4] & ~cols);
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic model_reset();
        hist.delete();
        hist.push_back('0);
        m_deb = '0;
        m_active = 0;
        m_mk = 0;
        f_idx = 0;
    endtask
    task automatic add(input int r, input int c);
        if (!evt_if.evt_ready && exp_q.size() >= DEPTH) ovf_exp++;
        else exp_q.push_back('{c, r, evt_if.evt_ready ? 16 * (f_idx + 1) + 1 : -1});
    endtask
    task automatic model_frame(input logic [15:0] m);
        int n, c;
        bit same;
        hist.push_back(m);
        if (hist.size() > DEB + 1) void'(hist.pop_front());
        same = hist.size() == DEB + 1;
        foreach (hist[i]) if (hist[i] != m) same = 0;
        if (same) m_deb = m;
        n = $countones(m_deb);
        m_mk = n > 1;
        if (n == 1) begin
            c = $clog2(m_deb);
            if (!m_active || c != m_cur) begin
                add(0, c);
                m_active = 1;
                m_cur = c;
                m_held = 0;
            end else begin
                m_held++;
                if (RATE != 0 && m_held >= DELAY && (m_held - DELAY) % RATE == 0) add(1, c);
            end
        end else m_active = 0;
        f_idx++;
    endtask
    task automatic frame(input logic [15:0] m);
        keys = m;
        model_frame(m);
        repeat (16) @(negedge clk);
        chk("multi_key", 32'(multi_key), 32'(m_mk));
    endtask
    task automatic reset_values(input string tag);
        chk({tag, "_cols"}, 32'(cols), 32'hE);
        chk({tag, "_valid"}, 32'(evt_if.evt_valid), 0);
        chk({tag, "_code"}, 32'(evt_if.evt_code), 0);
        chk({tag, "_repeat"}, 32'(evt_if.evt_repeat), 0);
        chk({tag, "_multi"}, 32'(multi_key), 0);
        chk({tag, "_overflow"}, 32'(overflow), 0);
    endtask
    always @(negedge clk) begin
        #2;
        if (reset) stall_prev = 0;
        else begin
            if (stall_prev) begin
                checks++;
                assert (evt_if.evt_valid === 1'b1 && evt_if.evt_code === p_code && evt_if.evt_repeat === p_rep) else begin
                    fails++;
                    $error("FAIL head_stable got v=%b code=%0d rep=%b exp v=1 code=%0d rep=%b",
                           evt_if.evt_valid, evt_if.evt_code, evt_if.evt_repeat, p_code, p_rep);
                end
            end
            stall_prev = evt_if.evt_valid === 1'b1 && evt_if.evt_ready === 1'b0;
            p_code = evt_if.evt_code;
            p_rep = evt_if.evt_repeat;
            if (overflow === 1'b1) ovf_seen++;
            if (evt_if.evt_valid === 1'b1 && evt_if.evt_ready === 1'b1) begin
                n_seen++;
                checks++;
                assert (exp_q.size() != 0) else begin
                    fails++;
                    $error("FAIL extra_event got code=%0d rep=%b at cyc=%0d exp none", evt_if.evt_code, evt_if.evt_repeat, cyc);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    assert (evt_if.evt_code === 4'(e.code) && evt_if.evt_repeat === 1'(e.rpt) && (e.cyc < 0 || cyc == e.cyc)) else begin
                        fails++;
                        $error("FAIL event got code=%0d rep=%b cyc=%0d exp code=%0d rep=%0d cyc=%0d",
                               evt_if.evt_code, evt_if.evt_repeat, cyc, e.code, e.rpt, e.cyc);
                    end
                end
            end
        end
    end
    initial begin
        logic [15:0] m;
        int k;
        evt_if.evt_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset_values("reset");
        reset = 1'b0;
        model_reset();
        repeat (3) frame(16'h1 << 6);
        repeat (3) frame('0);
        chk("t1_one_event", n_seen, 1);
        frame(16'h1);
        repeat (3) frame('0);
        chk("t2_glitch_no_event", n_seen, 1);
        repeat (10) frame(16'h1 << 5);
        repeat (3) frame('0);
        repeat (3) frame(16'h8001);
        chk("t4_multi_no_event", n_seen, 6);
        repeat (3) frame(16'h1);
        repeat (3) frame('0);
        chk("t4_press_after_multi", n_seen, 7);
        evt_if.evt_ready = 1'b0;
        repeat (3) frame(16'h1 << 3);
        repeat (3) frame(16'h1 << 9);
        repeat (3) frame(16'h1 << 12);
        repeat (3) frame('0);
        chk("t5_overflow_pulses", ovf_seen, 1);
        chk("t5_head_valid", 32'(evt_if.evt_valid), 1);
        chk("t5_head_code", 32'(evt_if.evt_code), 3);
        evt_if.evt_ready = 1'b1;
        frame('0);
        chk("t5_retained", n_seen, 9);
        for (int s = 0; s < 40; s++) begin
            k = $urandom_range(0, 3);
            m = k == 0 ? 16'h0 : k < 3 ? 16'h1 << $urandom_range(0, 15) :
                (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            repeat ($urandom_range(1, 6)) frame(m);
        end
        repeat (3) frame('0);
        repeat (3) frame(16'h1 << 10);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        reset_values("midreset");
        repeat (2) @(negedge clk);
        k = n_seen;
        reset = 1'b0;
        model_reset();
        repeat (3) frame(16'h1 << 10);
        repeat (3) frame('0);
        chk("t6_rereport", n_seen - k, 1);
        chk("pending_events", exp_q.size(), 0);
        chk("overflow_total", ovf_seen, ovf_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
